// File: rtl/xpb_pkg.sv
// Shared definitions for the runtime-loadable XPB lookup bank.
package xpb_pkg;

    localparam int IDX_BITS_DEF  = 5;
    localparam int WORD_BITS_DEF = 1024;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        READY
    } lut_state_e;

    // Number of stored residues: index 0 is implicit zero, so it is never loaded.
    function automatic int lut_words(input int idx_bits, input int num_ch);
        return num_ch * ((1 << idx_bits) - 1);
    endfunction

endpackage

// File: rtl/xpb_lut_bank_if.sv
// Host load bus and parallel lookup bus of the XPB lookup bank.
interface xpb_lut_bank_if
    import xpb_pkg::*;
#(
    parameter int IDX_BITS  = IDX_BITS_DEF,
    parameter int WORD_BITS = WORD_BITS_DEF,
    parameter int NUM_CH    = 4
);

    logic                          load_start;
    logic                          wr_valid;
    logic                          wr_ready;
    logic [WORD_BITS-1:0]          wr_data;
    logic                          tbl_ready;
    logic                          lk_valid;
    logic [NUM_CH*IDX_BITS-1:0]    lk_idx;
    logic                          lk_valid_o;
    logic [NUM_CH*WORD_BITS-1:0]   lk_data;
    logic                          lk_err;

    modport master (
        output load_start, wr_valid, wr_data, lk_valid, lk_idx,
        input  wr_ready, tbl_ready, lk_valid_o, lk_data, lk_err
    );

    modport slave (
        input  load_start, wr_valid, wr_data, lk_valid, lk_idx,
        output wr_ready, tbl_ready, lk_valid_o, lk_data, lk_err
    );

endinterface

// File: rtl/xpb_lut_ram.sv
// One channel's residue table: 1W/1R RAM with synchronous read; entry k holds index k+1.
module xpb_lut_ram
    import xpb_pkg::*;
#(
    parameter int IDX_BITS  = IDX_BITS_DEF,
    parameter int WORD_BITS = WORD_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [IDX_BITS-1:0]  wr_addr,
    input  logic [WORD_BITS-1:0] wr_data,
    input  logic                 rd_en,
    input  logic [IDX_BITS-1:0]  rd_addr,
    output logic [WORD_BITS-1:0] rd_data
);

    localparam int DEPTH = (1 << IDX_BITS) - 1;

    logic [WORD_BITS-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read data is held while rd_en is low so the bank output can hold too.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/xpb_lut_bank.sv
// Multi-channel XPB lookup: host load FSM writes per-channel tables, lookups run in a 2-stage pipeline.
module xpb_lut_bank
    import xpb_pkg::*;
#(
    parameter int IDX_BITS  = IDX_BITS_DEF,
    parameter int WORD_BITS = WORD_BITS_DEF,
    parameter int NUM_CH    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    xpb_lut_bank_if.slave bus
);

    localparam int IDX_MAX     = (1 << IDX_BITS) - 1;
    localparam int CH_BITS     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int TOTAL_WORDS = lut_words(IDX_BITS, NUM_CH);

    lut_state_e          state;
    logic [CH_BITS-1:0]  wr_ch;
    logic [IDX_BITS-1:0] wr_idx;
    logic                wr_ready_q;
    logic                tbl_ready_q;
    logic                accept;
    logic                last_word;

    assign accept    = bus.wr_valid && wr_ready_q;
    assign last_word = accept && ((int'(wr_ch) * IDX_MAX + int'(wr_idx)) == TOTAL_WORDS);

    // load_start from any state restarts the load, including on the last word's cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            wr_ch       <= '0;
            wr_idx      <= '0;
            wr_ready_q  <= 1'b0;
            tbl_ready_q <= 1'b0;
        end else if (bus.load_start) begin
            state       <= LOAD;
            wr_ch       <= '0;
            wr_idx      <= IDX_BITS'(1);
            wr_ready_q  <= 1'b1;
            tbl_ready_q <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (last_word) begin
                        state       <= READY;
                        wr_ready_q  <= 1'b0;
                        tbl_ready_q <= 1'b1;
                    end else if (accept) begin
                        if (wr_idx == IDX_BITS'(IDX_MAX)) begin
                            wr_idx <= IDX_BITS'(1);
                            wr_ch  <= wr_ch + 1'b1;
                        end else begin
                            wr_idx <= wr_idx + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.wr_ready  = wr_ready_q;
    assign bus.tbl_ready = tbl_ready_q;

    logic                       s1_valid;
    logic                       s1_rdy;
    logic [NUM_CH*IDX_BITS-1:0] s1_idx;
    logic [NUM_CH-1:0]          zero_next;
    logic [NUM_CH-1:0]          zero_q;
    logic                       lk_valid_q;
    logic                       lk_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_rdy   <= 1'b0;
            s1_idx   <= '0;
        end else begin
            s1_valid <= bus.lk_valid;
            s1_rdy   <= tbl_ready_q;
            s1_idx   <= bus.lk_idx;
        end
    end

    always_comb begin
        zero_next = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            zero_next[c] = !s1_rdy || (s1_idx[c*IDX_BITS +: IDX_BITS] == '0);
        end
    end

    // Per-channel zero mask is registered beside the RAM read so data and error hold together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lk_valid_q <= 1'b0;
            lk_err_q   <= 1'b0;
            zero_q     <= '1;
        end else begin
            lk_valid_q <= s1_valid;
            if (s1_valid) begin
                lk_err_q <= !s1_rdy;
                zero_q   <= zero_next;
            end
        end
    end

    assign bus.lk_valid_o = lk_valid_q;
    assign bus.lk_err     = lk_err_q;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [IDX_BITS-1:0]  ch_idx;
        logic [WORD_BITS-1:0] rd_q;

        assign ch_idx = s1_idx[c*IDX_BITS +: IDX_BITS];

        xpb_lut_ram #(
            .IDX_BITS  (IDX_BITS),
            .WORD_BITS (WORD_BITS)
        ) u_ram (
            .clk     (clk),
            .wr_en   (accept && (wr_ch == CH_BITS'(c))),
            .wr_addr (wr_idx - 1'b1),
            .wr_data (bus.wr_data),
            .rd_en   (s1_valid && s1_rdy && (ch_idx != '0)),
            .rd_addr (ch_idx - 1'b1),
            .rd_data (rd_q)
        );

        assign bus.lk_data[c*WORD_BITS +: WORD_BITS] = zero_q[c] ? '0 : rd_q;
    end

endmodule

// File: tb/tb_xpb_lut_bank.sv
// Randomized self-checking bench for xpb_lut_bank against a table/queue reference model.
module tb_xpb_lut_bank;

    localparam int IB    = 2;
    localparam int WB    = 16;
    localparam int NC    = 2;
    localparam int IMAX  = (1 << IB) - 1;
    localparam int TOTAL = NC * IMAX;
    localparam int LKW   = NC * IB;
    localparam int DW    = NC * WB;
    localparam int MAXC  = 4096;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    xpb_lut_bank_if #(.IDX_BITS(IB), .WORD_BITS(WB), .NUM_CH(NC)) bus ();

    xpb_lut_bank #(.IDX_BITS(IB), .WORD_BITS(WB), .NUM_CH(NC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference: what the host has written, whether a full load has completed,
    // and the lookup results due at each future cycle.
    logic [WB-1:0] tbl [NC][IMAX+1];
    bit            m_loading;
    bit            m_ready;
    int            m_count;
    int            cyc;
    bit            exp_v [MAXC];
    logic [DW-1:0] exp_d [MAXC];
    bit            exp_e [MAXC];
    logic [DW-1:0] cur_d;
    bit            cur_e;
    int            n_checks;
    int            n_fail;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic checkCycle();
        if (exp_v[cyc]) begin
            cur_d = exp_d[cyc];
            cur_e = exp_e[cyc];
        end
        checkOutput("wr_ready",   64'(bus.wr_ready),   64'(m_loading));
        checkOutput("tbl_ready",  64'(bus.tbl_ready),  64'(m_ready));
        checkOutput("lk_valid_o", 64'(bus.lk_valid_o), 64'(exp_v[cyc]));
        checkOutput("lk_data",    64'(bus.lk_data),    64'(cur_d));
        checkOutput("lk_err",     64'(bus.lk_err),     64'(cur_e));
    endtask

    task automatic applyStimulus(input bit ls, input bit wv, input logic [WB-1:0] wd,
                                 input bit lv, input logic [LKW-1:0] idx);
        logic [DW-1:0] d;
        checkCycle();
        bus.load_start = ls;
        bus.wr_valid   = wv;
        bus.wr_data    = wd;
        bus.lk_valid   = lv;
        bus.lk_idx     = idx;
        if (lv) begin
            d = '0;
            for (int c = 0; c < NC; c++) begin
                int i;
                i = int'(idx[c*IB +: IB]);
                if (m_ready && i != 0) d[c*WB +: WB] = tbl[c][i];
            end
            exp_v[cyc+2] = 1'b1;
            exp_d[cyc+2] = d;
            exp_e[cyc+2] = !m_ready;
        end
        if (ls) begin
            m_loading = 1'b1;
            m_ready   = 1'b0;
            m_count   = 0;
        end else if (wv && m_loading) begin
            tbl[m_count / IMAX][m_count % IMAX + 1] = wd;
            m_count++;
            if (m_count == TOTAL) begin
                m_loading = 1'b0;
                m_ready   = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic lookup(input logic [LKW-1:0] idx);
        applyStimulus(1'b0, 1'b0, '0, 1'b1, idx);
    endtask

    task automatic doReset(input int ncyc);
        rst_n          = 1'b0;
        bus.load_start = 1'b0;
        bus.wr_valid   = 1'b0;
        bus.wr_data    = '0;
        bus.lk_valid   = 1'b0;
        bus.lk_idx     = '0;
        #1;
        for (int k = cyc; k < cyc + ncyc + 4; k++) exp_v[k] = 1'b0;
        cur_d     = '0;
        cur_e     = 1'b0;
        m_loading = 1'b0;
        m_ready   = 1'b0;
        m_count   = 0;
        repeat (ncyc) begin
            checkCycle();
            @(posedge clk);
            #1;
            cyc++;
        end
        rst_n = 1'b1;
    endtask

    task automatic fullLoad(input logic [WB-1:0] base);
        applyStimulus(1'b1, 1'b0, '0, 1'b0, '0);
        for (int k = 0; k < TOTAL; k++) applyStimulus(1'b0, 1'b1, base + WB'(k), 1'b0, '0);
    endtask

    initial begin
        logic [WB-1:0] words [TOTAL];
        int sent;
        int guard;
        bit wv;
        bit lv;

        words = '{16'h0011, 16'h0012, 16'h0013, 16'h0021, 16'h0022, 16'h0023};
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        bus.load_start = 1'b0;
        bus.wr_valid   = 1'b0;
        bus.wr_data    = '0;
        bus.lk_valid   = 1'b0;
        bus.lk_idx     = '0;
        @(posedge clk);
        #1;
        doReset(3);

        // Lookup before any load reports an error with zero data.
        lookup({2'd1, 2'd3});
        idle(3);

        applyStimulus(1'b1, 1'b0, '0, 1'b0, '0);
        for (int k = 0; k < TOTAL; k++) applyStimulus(1'b0, 1'b1, words[k], 1'b0, '0);
        idle(2);

        lookup({2'd3, 2'd1});
        lookup({2'd0, 2'd2});
        lookup({2'd1, 2'd0});
        idle(3);

        // Restart after three words, then a fresh full load.
        applyStimulus(1'b1, 1'b0, '0, 1'b0, '0);
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b1, 16'h0aa0 + WB'(k), 1'b0, '0);
        fullLoad(16'h0101);
        idle(1);
        lookup({2'd1, 2'd3});
        idle(3);

        // Gapped load with a lookup on the last word's cycle and one right after.
        applyStimulus(1'b1, 1'b0, '0, 1'b0, '0);
        sent  = 0;
        guard = 0;
        while (sent < TOTAL && guard < 200) begin
            wv = ($urandom_range(0, 2) != 0);
            lv = wv && (sent == TOTAL - 1);
            applyStimulus(1'b0, wv, WB'($urandom), lv, LKW'($urandom));
            if (wv) sent++;
            guard++;
        end
        checkOutput("gapped_load_done", 64'(sent), 64'(TOTAL));
        lookup(LKW'($urandom));
        idle(3);

        for (int k = 0; k < 300; k++) begin
            applyStimulus($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, WB'($urandom),
                          $urandom_range(0, 1) == 1, LKW'($urandom));
        end
        idle(3);

        // Reset with lookups in flight and a half-finished load.
        fullLoad(16'h0200);
        applyStimulus(1'b1, 1'b0, '0, 1'b0, '0);
        applyStimulus(1'b0, 1'b1, 16'h0301, 1'b0, '0);
        applyStimulus(1'b0, 1'b1, 16'h0302, 1'b1, {2'd1, 2'd1});
        applyStimulus(1'b0, 1'b1, 16'h0303, 1'b1, {2'd2, 2'd3});
        doReset(2);
        idle(2);
        lookup({2'd3, 2'd2});
        fullLoad(16'h0400);
        for (int k = 0; k < 8; k++) lookup(LKW'($urandom));
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
